// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-port types for the MEM stage.
//   mem_ctrl_t        [1]=read (MEM_RD), [0]=write (MEM_WR)
//   arb_lock_state_t  bus-lock FSM states of mem_arbiter
//   arb_id_t          requester port ID (0 = load/store, 1 = debug/loader)
package mem_pkg;

    typedef logic [1:0] mem_ctrl_t;

    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    typedef enum logic [1:0] {
        ARB_UNLOCKED = 2'd0,
        ARB_LOCKED0  = 2'd1,
        ARB_LOCKED1  = 2'd2
    } arb_lock_state_t;

    typedef logic arb_id_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: 2-way round-robin picker.
//   eligible  in  2  per-port eligibility (already lock-masked by the parent)
//   last      in  1  port granted most recently
//   gnt       out 2  one-hot grant, 0 when nothing is eligible
module mem_arb_rr2
    import mem_pkg::*;
(
    input  logic [1:0] eligible,
    input  arb_id_t    last,
    output logic [1:0] gnt
);

    assign gnt[0] = eligible[0] && (!eligible[1] || last == 1'b1);
    assign gnt[1] = eligible[1] && (!eligible[0] || last == 1'b0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the MEM-stage data-memory port between the load/store
// path (port 0) and the debug/program-loader master (port 1).
//   i_clk, i_reset (async, active-high)
//   i_reqN, i_ctrlN, i_addrN, i_wdataN, i_lockN  requester side, N = 0/1
//   o_gntN (combinational), o_rvalidN/o_rdataN   requester responses
//   o_memAddr, o_writeData, o_ctrlMEM, i_readData memory side
// Optional bus lock: define MEM_ARB_LOCK_EN to enable the lock FSM; otherwise
// the lock inputs are ignored and arbitration is pure round-robin.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  mem_ctrl_t   i_ctrl0,
    input  mem_ctrl_t   i_ctrl1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    input  logic        i_lock0,
    input  logic        i_lock1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_writeData,
    output mem_ctrl_t   o_ctrlMEM,
    input  logic [31:0] i_readData
);

    logic [1:0]      elig_raw, elig, gnt;
    arb_id_t         rr_q, rsp_id_q;
    logic            rsp_valid_q;
    arb_lock_state_t lock_state;
    mem_ctrl_t       ctrl_m0, ctrl_m1;

    assign elig_raw = {i_req1 && i_ctrl1 != '0, i_req0 && i_ctrl0 != '0};

    // Reset forces all grants off; a held lock hides the other port.
    assign elig = i_reset                     ? 2'b00 :
                  lock_state == ARB_LOCKED0   ? {1'b0, elig_raw[0]} :
                  lock_state == ARB_LOCKED1   ? {elig_raw[1], 1'b0} : elig_raw;

    mem_arb_rr2 u_rr (
        .eligible (elig),
        .last     (rr_q),
        .gnt      (gnt)
    );

    assign o_gnt0 = gnt[0];
    assign o_gnt1 = gnt[1];

    // ctrl=11 is illegal: keep the write, drop the read so no response is expected.
    assign ctrl_m0 = {i_ctrl0[MEM_RD] & ~i_ctrl0[MEM_WR], i_ctrl0[MEM_WR]};
    assign ctrl_m1 = {i_ctrl1[MEM_RD] & ~i_ctrl1[MEM_WR], i_ctrl1[MEM_WR]};

    assign o_ctrlMEM   = gnt[0] ? ctrl_m0  : gnt[1] ? ctrl_m1  : '0;
    assign o_memAddr   = gnt[0] ? i_addr0  : gnt[1] ? i_addr1  : '0;
    assign o_writeData = gnt[0] ? i_wdata0 : gnt[1] ? i_wdata1 : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            if (|gnt) rr_q <= gnt[1];
            rsp_valid_q <= o_ctrlMEM[MEM_RD];
            rsp_id_q    <= gnt[1];
        end
    end

    // Memory read data arrives the cycle after issue; steer it to the issuer.
    assign o_rvalid0 = rsp_valid_q && rsp_id_q == 1'b0;
    assign o_rvalid1 = rsp_valid_q && rsp_id_q == 1'b1;
    assign o_rdata0  = o_rvalid0 ? i_readData : '0;
    assign o_rdata1  = o_rvalid1 ? i_readData : '0;

`ifdef MEM_ARB_LOCK_EN
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_TIMEOUT - 1);

    logic [7:0] lock_cnt;
    logic       own_req, own_gnt, own_lock;

    assign own_req  = lock_state == ARB_LOCKED0 ? i_req0  : i_req1;
    assign own_gnt  = lock_state == ARB_LOCKED0 ? gnt[0]  : gnt[1];
    assign own_lock = lock_state == ARB_LOCKED0 ? i_lock0 : i_lock1;

    // The timeout exit grant already leaves rr_q pointing at the owner,
    // so the other port wins the following contention.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lock_state <= ARB_UNLOCKED;
            lock_cnt   <= '0;
        end else if (lock_state == ARB_UNLOCKED) begin
            if (LOCK_TIMEOUT > 1 && ((gnt[0] && i_lock0) || (gnt[1] && i_lock1))) begin
                lock_state <= gnt[0] ? ARB_LOCKED0 : ARB_LOCKED1;
                lock_cnt   <= 8'd1;
            end
        end else if (!own_req || (own_gnt && (!own_lock || lock_cnt == LOCK_LAST))) begin
            lock_state <= ARB_UNLOCKED;
            lock_cnt   <= '0;
        end else if (own_gnt) begin
            lock_cnt <= lock_cnt + 8'd1;
        end
    end
`else
    logic unused_lock;

    assign lock_state  = ARB_UNLOCKED;
    assign unused_lock = i_lock0 ^ i_lock1;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req0 = 1'b0, i_req1 = 1'b0;
    mem_ctrl_t   i_ctrl0 = '0, i_ctrl1 = '0;
    logic [31:0] i_addr0 = '0, i_addr1 = '0;
    logic [31:0] i_wdata0 = '0, i_wdata1 = '0;
    logic        i_lock0 = 1'b0, i_lock1 = 1'b0;
    logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
    logic [31:0] o_rdata0, o_rdata1, o_memAddr, o_writeData;
    mem_ctrl_t   o_ctrlMEM;
    logic [31:0] i_readData = '0;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.LOCK_TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req0      (i_req0),
        .i_req1      (i_req1),
        .i_ctrl0     (i_ctrl0),
        .i_ctrl1     (i_ctrl1),
        .i_addr0     (i_addr0),
        .i_addr1     (i_addr1),
        .i_wdata0    (i_wdata0),
        .i_wdata1    (i_wdata1),
        .i_lock0     (i_lock0),
        .i_lock1     (i_lock1),
        .o_gnt0      (o_gnt0),
        .o_gnt1      (o_gnt1),
        .o_rvalid0   (o_rvalid0),
        .o_rvalid1   (o_rvalid1),
        .o_rdata0    (o_rdata0),
        .o_rdata1    (o_rdata1),
        .o_memAddr   (o_memAddr),
        .o_writeData (o_writeData),
        .o_ctrlMEM   (o_ctrlMEM),
        .i_readData  (i_readData)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_req0 = 0; i_req1 = 0; i_ctrl0 = '0; i_ctrl1 = '0;
        i_lock0 = 0; i_lock1 = 0; i_readData = '0;
    endtask

    task automatic do_reset();
        i_reset = 1;
        tick();
        tick();
        i_reset = 0;
    endtask

    initial begin
        // Reset state, with a request present to prove grants are blocked.
        tick();
        i_reset = 1;
        i_req0 = 1; i_ctrl0 = 2'b10; i_addr0 = 32'h40;
        #1;
        chk("rst_gnt0", 32'(o_gnt0), 32'd0);
        chk("rst_ctrl", 32'(o_ctrlMEM), 32'd0);
        chk("rst_addr", o_memAddr, 32'd0);
        tick();
        chk("rst_rvalid0", 32'(o_rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(o_rvalid1), 32'd0);
        chk("rst_rdata0", o_rdata0, 32'd0);
        chk("rst_rdata1", o_rdata1, 32'd0);
        idle();
        tick();
        i_reset = 0;
        tick();

        // Port 0 read of 0x100 alone.
        i_req0 = 1; i_ctrl0 = 2'b10; i_addr0 = 32'h100;
        #1;
        chk("rd0_gnt0", 32'(o_gnt0), 32'd1);
        chk("rd0_gnt1", 32'(o_gnt1), 32'd0);
        chk("rd0_ctrl", 32'(o_ctrlMEM), 32'h2);
        chk("rd0_addr", o_memAddr, 32'h100);
        tick();
        idle();
        i_readData = 32'hDEADBEEF;
        #1;
        chk("rd0_rvalid0", 32'(o_rvalid0), 32'd1);
        chk("rd0_rdata0", o_rdata0, 32'hDEADBEEF);
        chk("rd0_rvalid1", 32'(o_rvalid1), 32'd0);
        chk("rd0_rdata1", o_rdata1, 32'd0);
        tick();
        chk("rd0_rvalid0_once", 32'(o_rvalid0), 32'd0);
        chk("rd0_rdata0_zero", o_rdata0, 32'd0);

        // Steady write contention from reset: 0,1,0,1...
        do_reset();
        i_req0 = 1; i_ctrl0 = 2'b01; i_addr0 = 32'h0; i_wdata0 = 32'hAAAA0000;
        i_req1 = 1; i_ctrl1 = 2'b01; i_addr1 = 32'h4; i_wdata1 = 32'hBBBB1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("alt%0d_gnt0", i), 32'(o_gnt0), 32'(i % 2 == 0));
            chk($sformatf("alt%0d_gnt1", i), 32'(o_gnt1), 32'(i % 2 == 1));
            chk($sformatf("alt%0d_ctrl", i), 32'(o_ctrlMEM), 32'h1);
            chk($sformatf("alt%0d_addr", i), o_memAddr, (i % 2 == 0) ? 32'h0 : 32'h4);
            chk($sformatf("alt%0d_wdata", i), o_writeData, (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB1111);
            tick();
        end
        chk("alt_no_rvalid", 32'({o_rvalid1, o_rvalid0}), 32'd0);
        idle();

        // Back-to-back reads from port 1 then port 0: no cross-routing.
        i_req1 = 1; i_ctrl1 = 2'b10; i_addr1 = 32'h200;
        #1;
        chk("b2b_gnt1", 32'(o_gnt1), 32'd1);
        chk("b2b_addr1", o_memAddr, 32'h200);
        tick();
        i_req1 = 0; i_ctrl1 = '0;
        i_req0 = 1; i_ctrl0 = 2'b10; i_addr0 = 32'h300;
        i_readData = 32'h11111111;
        #1;
        chk("b2b_gnt0", 32'(o_gnt0), 32'd1);
        chk("b2b_addr0", o_memAddr, 32'h300);
        chk("b2b_rvalid1", 32'(o_rvalid1), 32'd1);
        chk("b2b_rdata1", o_rdata1, 32'h11111111);
        chk("b2b_rvalid0_early", 32'(o_rvalid0), 32'd0);
        chk("b2b_rdata0_early", o_rdata0, 32'd0);
        tick();
        idle();
        i_readData = 32'h22222222;
        #1;
        chk("b2b_rvalid0", 32'(o_rvalid0), 32'd1);
        chk("b2b_rdata0", o_rdata0, 32'h22222222);
        chk("b2b_rvalid1_late", 32'(o_rvalid1), 32'd0);
        chk("b2b_rdata1_late", o_rdata1, 32'd0);
        tick();

        // Lock behaviour with LOCK_TIMEOUT=4.
        do_reset();
        i_req0 = 1; i_ctrl0 = 2'b01; i_addr0 = 32'h10; i_lock0 = 1;
        i_req1 = 1; i_ctrl1 = 2'b01; i_addr1 = 32'h20;
        #1;
`ifdef MEM_ARB_LOCK_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock%0d_gnt0", i), 32'(o_gnt0), 32'd1);
            chk($sformatf("lock%0d_gnt1", i), 32'(o_gnt1), 32'd0);
            tick();
        end
        chk("lock_to_gnt1", 32'(o_gnt1), 32'd1);
        chk("lock_to_gnt0", 32'(o_gnt0), 32'd0);
`else
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("nolock%0d_gnt0", i), 32'(o_gnt0), 32'(i % 2 == 0));
            chk($sformatf("nolock%0d_gnt1", i), 32'(o_gnt1), 32'(i % 2 == 1));
            tick();
        end
`endif
        idle();
        tick();

        // ctrl=00 is ignored; ctrl=11 goes out as a write with no response.
        i_req0 = 1; i_ctrl0 = 2'b00; i_addr0 = 32'h80; i_wdata0 = 32'h12345678;
        #1;
        chk("c00_gnt0", 32'(o_gnt0), 32'd0);
        chk("c00_ctrl", 32'(o_ctrlMEM), 32'd0);
        chk("c00_addr", o_memAddr, 32'd0);
        chk("c00_wdata", o_writeData, 32'd0);
        tick();
        i_ctrl0 = 2'b11;
        #1;
        chk("c11_gnt0", 32'(o_gnt0), 32'd1);
        chk("c11_ctrl", 32'(o_ctrlMEM), 32'h1);
        chk("c11_addr", o_memAddr, 32'h80);
        chk("c11_wdata", o_writeData, 32'h12345678);
        tick();
        idle();
        i_readData = 32'hCAFEF00D;
        #1;
        chk("c11_rvalid0", 32'(o_rvalid0), 32'd0);
        chk("c11_rdata0", o_rdata0, 32'd0);
        tick();

        // Asynchronous reset mid-cycle drops a pending read.
        i_req0 = 1; i_ctrl0 = 2'b10; i_addr0 = 32'h400;
        #1;
        chk("arst_gnt_before", 32'(o_gnt0), 32'd1);
        #2;
        i_reset = 1;
        #1;
        chk("arst_gnt0", 32'(o_gnt0), 32'd0);
        chk("arst_ctrl", 32'(o_ctrlMEM), 32'd0);
        chk("arst_addr", o_memAddr, 32'd0);
        tick();
        i_readData = 32'h99999999;
        #1;
        chk("arst_rvalid0", 32'(o_rvalid0), 32'd0);
        chk("arst_rdata0", o_rdata0, 32'd0);
        tick();
        i_reset = 0;
        idle();
        i_readData = 32'h99999999;
        #1;
        chk("arst_rel_rvalid0", 32'(o_rvalid0), 32'd0);
        chk("arst_rel_rvalid1", 32'(o_rvalid1), 32'd0);
        i_req0 = 1; i_ctrl0 = 2'b10; i_addr0 = 32'h500;
        i_req1 = 1; i_ctrl1 = 2'b10; i_addr1 = 32'h600;
        #1;
        chk("arst_contend_gnt0", 32'(o_gnt0), 32'd1);
        chk("arst_contend_gnt1", 32'(o_gnt1), 32'd0);
        chk("arst_contend_addr", o_memAddr, 32'h500);
        tick();
        idle();
        i_readData = 32'h55555555;
        #1;
        chk("arst_post_rvalid0", 32'(o_rvalid0), 32'd1);
        chk("arst_post_rdata0", o_rdata0, 32'h55555555);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single data-memory port of the MEM stage between the core's load/store path (port 0) and a debug/program-loader master (port 1). It issues at most one transaction per cycle to memory using the existing `mem_ctrl_t` encoding ([1]=read, [0]=write), and routes each read response back to the requester that issued it. It uses round-robin fairness, with an optional bus-lock for atomic read-modify-write sequences. It sits between the requesters and the memory block; the memory logger taps the arbiter's memory-side outputs.

## Interface
- LOCK_TIMEOUT, 16: maximum consecutive locked grants before the lock is forcibly broken (1..255).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req0 / i_req1  in  1  request from port 0 / port 1; request and payload are held stable until the matching grant.
- i_ctrl0 / i_ctrl1  in  mem_ctrl_t  requested operation.
- i_addr0 / i_addr1  in  32  byte address.
- i_wdata0 / i_wdata1  in  32  write data.
- i_lock0 / i_lock1  in  1  request to keep ownership after this grant (used only with MEM_ARB_LOCK_EN).
- o_gnt0 / o_gnt1  out  1  transaction accepted this cycle (combinational).
- o_rvalid0 / o_rvalid1  out  1  read data valid for that port (registered).
- o_rdata0 / o_rdata1  out  32  read data; 0 when the matching rvalid is low.
- o_memAddr  out  32  address to memory.
- o_writeData  out  32  write data to memory.
- o_ctrlMEM  out  mem_ctrl_t  operation to memory; 0 when idle.
- i_readData  in  32  memory read data, valid one cycle after a read is issued.

## Operation
- **Eligibility:** a port is eligible when `req=1` and `ctrl!=0`. A request with `ctrl=0` is ignored: no grant, no memory access.
- **Illegal `ctrl=2'b11`:** forwarded as a write only (read bit masked), granted, and no rvalid is produced.
- **Round-robin pointer `rr_q`:** holds the last granted port. When both ports are eligible, the port other than `rr_q` wins. When one port is eligible, it wins.
- **Reset priority:** `rr_q` resets to 1, so port 0 wins the first contention.
- **Memory outputs:** the winner's addr, wdata and ctrl drive the memory outputs. With no winner, `o_ctrlMEM=0`, and addr/wdata are 0.
- **Response tracking:** on a read grant, the response register captures the port ID. On the next cycle, the target port's `o_rvalid` is 1 and its `o_rdata` equals `i_readData`.
- **Pipelining:** a new transaction can be granted in the same cycle a response is returned, giving full throughput.
- **Lock FSM** (states UNLOCKED, LOCKED0, LOCKED1), active only with MEM_ARB_LOCK_EN:
  - UNLOCKED -> LOCKEDn: port n is granted with `i_lockn=1`; `lock_cnt` is set to 1.
  - In LOCKEDn, only port n is eligible. Each grant to port n increments `lock_cnt`.
  - LOCKEDn -> UNLOCKED when any of the following occurs:
    - port n is granted with `lock=0`;
    - port n has `req=0` for one cycle;
    - `lock_cnt == LOCK_TIMEOUT` at a grant.
  - On a timeout exit, `rr_q = n`, so the other port wins the next contention.
- **Reset:**
  - All grants are 0 and `o_ctrlMEM=0` while reset is asserted.
  - `rvalid=0` and `rdata=0`.
  - Lock state is UNLOCKED and `lock_cnt=0`.
  - A read pending across a reset assertion is dropped; no rvalid follows.

## Timing
- Request to grant: 0 cycles; grant is combinational from `req`, `ctrl`, `rr_q` and lock state.
- Read grant at cycle T: rvalid and rdata at cycle T+1, for exactly one cycle.
- Write: completes at the grant edge; no response.
- Steady contention with no lock: grants alternate 0,1,0,1.
- Locked: at most LOCK_TIMEOUT consecutive grants to one port; the other port is then served within one cycle if it is requesting.

## Configuration
- **MEM_ARB_LOCK_EN defined:** the lock FSM, `lock_cnt` and LOCK_TIMEOUT are active as described above.
- **MEM_ARB_LOCK_EN undefined:** the lock ports remain present but are ignored, the FSM is fixed at UNLOCKED, and arbitration is pure round-robin.

## Structure
- **Shared package `mem_pkg`:**
  - `mem_ctrl_t` and its bit constants (MEM_RD=1, MEM_WR=0);
  - the `arb_lock_state_t` enum;
  - the port-ID type `arb_id_t` (1 bit).
- **Sub-module `mem_arb_rr2`:** a 2-way round-robin picker (eligible[1:0] and last in, one-hot grant out). It keeps the lock masking in the parent.

## Test plan
- Port 0 reads 0x100 alone, memory returns 0xDEADBEEF -> `o_gnt0=1` at T; `o_rvalid0=1` and `o_rdata0=0xDEADBEEF` at T+1; `o_rvalid1=0`.
- Both ports request continuously, writes to 0x0 and 0x4 -> first grant to port 0 after reset, then strict alternation for 8 cycles; `o_ctrlMEM=01` every cycle.
- Port 1 read granted at T and port 0 read granted at T+1 -> `o_rvalid1` at T+1 with the T data, `o_rvalid0` at T+2; no cross-routing.
- MEM_ARB_LOCK_EN, LOCK_TIMEOUT=4, port 0 holding lock with port 1 requesting -> 4 grants to port 0, then port 1 granted on the 5th cycle.
- Port 0 requests with ctrl=0, then ctrl=11 -> no grant for the first; the second is granted as a write (`o_ctrlMEM=01`) with no rvalid.
- Read granted at T, reset asserted asynchronously mid-cycle T, released at T+2 -> all outputs 0 during reset, no rvalid after release, and port 0 wins the next contention.
